// File: rtl/int_src.sv
// -----------------------------------------------------------------------------
// int_src -- external interrupt source with an optional CP0 Count/Compare timer.
//
// Six asynchronous interrupt lines are synchronised and edge-detected.
// Each detected edge sets a sticky pending bit. A small FSM presents a
// snapshot of pending to the commit stage and holds it until the commit stage
// acknowledges it. When acknowledged, only the presented bits are cleared.
//
// Optional feature macro: TIMER_INT_EN
//   defined   : the Count/Compare timer drives pending[5] and irq_raw[5] is
//               ignored; Count and Compare can be read and written at CP0
//               addresses 8'h48 and 8'h58.
//   undefined : bit 5 is an ordinary external line and cp0_rdata is always 0.
//
// Ports
//   clk              : clock, rising edge
//   resetn           : asynchronous active-low reset
//   irq_raw[5:0]     : asynchronous interrupt lines, active-high
//   ext_int_response : commit stage has taken the presented interrupts
//   cp0_wen          : CP0 write strobe (MTC0 at commit)
//   cp0_addr[7:0]    : CP0 address {rd, sel}
//   cp0_wdata[31:0]  : CP0 write data
//   ext_int[5:0]     : registered interrupt vector presented to commit
//   cp0_rdata[31:0]  : combinational Count/Compare read data
//   busy             : registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module int_src (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  irq_raw,
    input  logic        ext_int_response,
    input  logic        cp0_wen,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [5:0]  ext_int,
    output logic [31:0] cp0_rdata,
    output logic        busy
);

    localparam int unsigned IRQ_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam logic [ADDR_W-1:0] COUNT_ADDR   = 8'h48;
    localparam logic [ADDR_W-1:0] COMPARE_ADDR = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Synchroniser and rising-edge detector
    // ---------------------------------------------------------------------
    logic [IRQ_W-1:0] sync1_q, sync1_d;
    logic [IRQ_W-1:0] sync2_q, sync2_d;
    logic [IRQ_W-1:0] sync_dly_q, sync_dly_d;
    logic [IRQ_W-1:0] edge_det;

    always_comb begin
        sync1_d    = irq_raw;
        sync2_d    = sync1_q;
        sync_dly_d = sync2_q;
        edge_det   = sync2_q & ~sync_dly_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_dly_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_dly_q <= sync_dly_d;
        end
    end

    // ---------------------------------------------------------------------
    // Interrupt set sources (timer replaces line 5 when enabled)
    // ---------------------------------------------------------------------
    logic [IRQ_W-1:0] irq_set;
    logic             compare_wr;

`ifdef TIMER_INT_EN
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              toggle_q, toggle_d;
    logic              count_inc;
    logic              count_wr;
    logic              timer_match;
    logic              unused_irq5;

    // Count advances on every cycle where the toggle bit is set; a Count
    // write suppresses that cycle's increment and restarts the toggle.
    always_comb begin
        count_wr    = cp0_wen && (cp0_addr == COUNT_ADDR);
        compare_wr  = cp0_wen && (cp0_addr == COMPARE_ADDR);
        count_inc   = toggle_q && !count_wr;
        toggle_d    = ~toggle_q;
        count_d     = count_q;
        compare_d   = compare_q;
        if (count_wr) begin
            count_d  = cp0_wdata;
            toggle_d = 1'b0;
        end else if (count_inc) begin
            count_d  = count_q + DATA_W'(1);
        end
        if (compare_wr) begin
            compare_d = cp0_wdata;
        end
        timer_match = count_inc && (count_d == compare_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            toggle_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
        end
    end

    // Read path shows the register value before any same-cycle write.
    always_comb begin
        cp0_rdata = '0;
        if (cp0_addr == COUNT_ADDR) begin
            cp0_rdata = count_q;
        end else if (cp0_addr == COMPARE_ADDR) begin
            cp0_rdata = compare_q;
        end
    end

    always_comb begin
        irq_set = {timer_match, edge_det[IRQ_W-2:0]};
    end

    assign unused_irq5 = edge_det[IRQ_W-1];
`else
    logic unused_cp0;

    always_comb begin
        irq_set    = edge_det;
        compare_wr = 1'b0;
        cp0_rdata  = '0;
    end

    assign unused_cp0 = ^{cp0_wen, cp0_addr, cp0_wdata};
`endif

    // ---------------------------------------------------------------------
    // Presentation FSM
    // ---------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IRQ_W-1:0] pending_q, pending_d;
    logic [IRQ_W-1:0] snap_q, snap_d;
    logic [IRQ_W-1:0] ext_int_q, ext_int_d;
    logic             busy_q, busy_d;
    logic [IRQ_W-1:0] clr_mask;

    // Next state, snapshot capture and registered output vector.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ext_int_d = '0;
        clr_mask  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d   = ST_PRESENT;
                    snap_d    = pending_q;
                    ext_int_d = pending_q;
                end
            end
            ST_PRESENT: begin
                ext_int_d = snap_q;
                if (ext_int_response) begin
                    state_d   = ST_HOLD;
                    clr_mask  = snap_q;
                    ext_int_d = '0;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Clear acknowledged bits first so a same-cycle edge still sets them;
    // a Compare write then drops the timer bit regardless of a match.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | irq_set;
        if (compare_wr) begin
            pending_d[IRQ_W-1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            snap_q    <= '0;
            ext_int_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            ext_int_q <= ext_int_d;
            busy_q    <= busy_d;
        end
    end

    assign ext_int = ext_int_q;
    assign busy    = busy_q;

endmodule

// File: doc/int_src.md
INT_SRC -- requirements
Module: int_src

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 resetn  input  1  asynchronous active-low reset.
REQ-003 irq_raw  input  6  asynchronous external interrupt lines, active-high.
REQ-004 ext_int_response  input  1  one-cycle pulse from the exception commit stage: presented interrupts were taken.
REQ-005 cp0_wen  input  1  CP0 write strobe from MTC0 in the commit stage.
REQ-006 cp0_addr  input  8  CP0 address {rd[4:0], sel[2:0]}; Count = 8'h48, Compare = 8'h58.
REQ-007 cp0_wdata  input  32  CP0 write data.
REQ-008 ext_int  output  6  interrupt vector presented to the commit stage.
REQ-009 cp0_rdata  output  32  Count or Compare read value, selected by cp0_addr; 0 for other addresses.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Each irq_raw bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sync & ~sync_d).
REQ-012 A detected edge on bit i SHALL set pending[i]; pending holds until cleared per REQ-016.
REQ-013 FSM states SHALL be IDLE, PRESENT and HOLD.
- IDLE->PRESENT when pending != 0.
- PRESENT->HOLD on ext_int_response.
- HOLD->IDLE unconditionally after 1 cycle.
REQ-014 On IDLE->PRESENT, snap SHALL latch pending; ext_int SHALL equal snap in PRESENT and 6'b0 in IDLE and HOLD (registered; no combinational path from irq_raw).
REQ-015 Edges arriving while in PRESENT SHALL set pending but SHALL NOT change snap or ext_int until the next IDLE->PRESENT.
REQ-016 On PRESENT->HOLD, pending SHALL clear exactly the snap bits; other bits are retained.
REQ-017 A new edge on bit i in the same cycle that bit i is cleared SHALL leave pending[i]=1 (set wins).
REQ-018 ext_int_response outside PRESENT SHALL be ignored.
REQ-019 Latency: irq_raw rise at edge N -> ext_int visible after edge N+4 when the FSM is idle (2 sync, 1 pending, 1 present).

Timer (see REQ-027)
REQ-020 Count SHALL increment by 1 every second clk cycle using a toggle bit; 32'hFFFFFFFF wraps to 0 with no flag.
REQ-021 A write to Count SHALL load cp0_wdata and reset the toggle bit to 0, overriding that cycle's increment.
REQ-022 When Count == Compare after an increment, the timer SHALL set pending[5].
REQ-023 A write to Compare SHALL load cp0_wdata and clear pending[5]. If a match occurs in the same cycle, the write wins.
REQ-024 cp0_rdata SHALL be combinational from cp0_addr and reflect the current register value (pre-write in a write cycle).

Reset
REQ-025 While resetn=0: sync flops, pending, snap = 0; FSM = IDLE; ext_int = 0; busy = 0; Count = 0; Compare = 0; toggle = 0; cp0_rdata follows REQ-024 from reset values.
REQ-026 Reset assertion mid-handshake (PRESENT or HOLD) SHALL abort immediately and drop ext_int to 0 asynchronously; all pending interrupts are lost.

Configuration
REQ-027 Macro TIMER_INT_EN: when defined, Count/Compare exist per REQ-020..024 and irq_raw[5] is ignored. When undefined, no timer logic exists, bit 5 behaves like bits 0..4 from irq_raw[5], and cp0_rdata = 0 for all addresses.

Verification
REQ-028 Reset, then irq_raw=6'b000010 for one cycle -> ext_int=6'b000010 four cycles later, held until ext_int_response; ext_int=0 on the cycle after the response.
REQ-029 Bit0 edge, then bit3 edge while in PRESENT -> first round ext_int=6'b000001; after response and HOLD, second round ext_int=6'b001000.
REQ-030 Bit1 edge detected in the same cycle as ext_int_response for a snap containing bit1 -> pending[1] stays 1 and bit1 is re-presented after HOLD.
REQ-031 TIMER_INT_EN defined: write Compare=10, Count=0 -> Count reaches 10 after 20 cycles, ext_int[5]=1 follows; write Compare=100 before the response -> pending[5] cleared.
REQ-032 Write Count=32'hFFFFFFFF, Compare=0 -> wrap to 0 after 2 cycles sets pending[5]; reset asserted in PRESENT -> ext_int=0 immediately, FSM=IDLE.
REQ-033 TIMER_INT_EN undefined: irq_raw[5] edge -> ext_int=6'b100000; reading cp0_addr 8'h48 returns 0.
